// File: rtl/fpu_operand_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_skid_if
// Description : Handshake bundle for the FPU operand skid buffer. It carries
//               the upstream operand channel (in_*), the downstream head
//               channel (out_*) and the special-pair counter.
//               slave  : the buffer's view.
//               master : the view of the surrounding logic or testbench.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_operand_skid_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_opa;
    logic [WIDTH-1:0] in_opb;
    logic             in_fast;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_opa;
    logic [WIDTH-1:0] out_opb;
    logic             out_fast;
    logic             out_sign_xor;
    logic             out_special;
    logic [CNT_W-1:0] special_cnt;

    modport slave (
        input  in_valid, in_opa, in_opb, in_fast, out_ready,
        output in_ready, out_valid, out_opa, out_opb, out_fast,
               out_sign_xor, out_special, special_cnt
    );

    modport master (
        output in_valid, in_opa, in_opb, in_fast, out_ready,
        input  in_ready, out_valid, out_opa, out_opb, out_fast,
               out_sign_xor, out_special, special_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fpu_operand_skid.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_skid
// Description : Two-entry elastic operand buffer in front of the operand-merge
//               stage. Each accepted (opa, opb, fast) pair is stored together
//               with its sign-xor and inf/NaN flags, which are computed at push
//               time. Pairs leave in strict FIFO order.
// Ports       : clk  - clock, all state updates on its rising edge
//               rst  - asynchronous active-high reset
//               bus  - fpu_operand_skid_if.slave:
//                      in_valid/in_ready/in_opa/in_opb/in_fast (upstream)
//                      out_valid/out_ready/out_opa/out_opb/out_fast/
//                      out_sign_xor/out_special (head entry)
//                      special_cnt (saturating count of special pops)
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fpu_operand_skid_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]       c_FULL    = 2'd2;

    // Entry storage
    logic [WIDTH-1:0] r_opa     [0:1];
    logic [WIDTH-1:0] r_opb     [0:1];
    logic             r_fast    [0:1];
    logic             r_sxor    [0:1];
    logic             r_special [0:1];

    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_special_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_in_sxor;
    logic w_in_special;

    // Handshake flags come only from registered state and rst. The upstream
    // stage is never given a combinational path from out_ready.
    assign w_in_ready  = ~rst & (r_count != c_FULL);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // An exponent field of all ones in either operand marks an inf or NaN pair.
    assign w_in_sxor    = bus.in_opa[WIDTH-1] ^ bus.in_opb[WIDTH-1];
    assign w_in_special = (&bus.in_opa[WIDTH-2 -: 8]) | (&bus.in_opb[WIDTH-2 -: 8]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_opa[i]     <= '0;
                r_opb[i]     <= '0;
                r_fast[i]    <= 1'b0;
                r_sxor[i]    <= 1'b0;
                r_special[i] <= 1'b0;
            end
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_special_cnt <= '0;
        end else begin
            if (w_push) begin
                r_opa[r_wr_ptr]     <= bus.in_opa;
                r_opb[r_wr_ptr]     <= bus.in_opb;
                r_fast[r_wr_ptr]    <= bus.in_fast;
                r_sxor[r_wr_ptr]    <= w_in_sxor;
                r_special[r_wr_ptr] <= w_in_special;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_special[r_rd_ptr] && (r_special_cnt != c_CNT_MAX)) begin
                    r_special_cnt <= r_special_cnt + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    // The head is shown as zero while the buffer is empty so stale data is never visible.
    assign bus.out_opa      = w_out_valid ? r_opa[r_rd_ptr]     : '0;
    assign bus.out_opb      = w_out_valid ? r_opb[r_rd_ptr]     : '0;
    assign bus.out_fast     = w_out_valid ? r_fast[r_rd_ptr]    : 1'b0;
    assign bus.out_sign_xor = w_out_valid ? r_sxor[r_rd_ptr]    : 1'b0;
    assign bus.out_special  = w_out_valid ? r_special[r_rd_ptr] : 1'b0;
    assign bus.special_cnt  = r_special_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpu_operand_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_operand_skid
// Description : Self-checking bench for fpu_operand_skid. It uses a table of
//               streaming vectors plus hand-written sequences for
//               backpressure, reset, push/pop at count 1, counter saturation
//               and fast-tag ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_operand_skid;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fpu_operand_skid_if #(.WIDTH(32), .CNT_W(8)) bus ();

    fpu_operand_skid #(.WIDTH(32), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] opa;
        logic [31:0] opb;
        logic        fast;
        logic        out_ready;
        logic        e_out_valid;
        logic        e_in_ready;
        logic [31:0] e_opa;
        logic [31:0] e_opb;
        logic        e_fast;
        logic        e_sxor;
        logic        e_special;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic r);
        bus.in_valid  = v;
        bus.in_opa    = a;
        bus.in_opb    = b;
        bus.in_fast   = f;
        bus.out_ready = r;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        #2 rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] q_opa  [$];
        logic        q_fast [$];
        logic [2:0]  fast_pat;
        logic [2:0]  fast_got;
        int          m;
        int          sent;
        int          got;
        logic        push;
        logic        pop;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        //                in_v opa           opb           f     ordy  ov    ir    e_opa         e_opb         ef    sx    sp    cnt
        tbl[0] = '{1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 32'hBF800000, 32'h40000000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 32'h7F800000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBF800000, 32'h40000000, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 32'h00000001, 32'h7FC00000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7F800000, 32'h00000000, 1'b1, 1'b0, 1'b1, 8'd0};
        tbl[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h00000001, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 8'd2};

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_cnt",       {24'd0, bus.special_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Streaming table
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].in_valid, tbl[i].opa, tbl[i].opb, tbl[i].fast, tbl[i].out_ready);
            #1;
            chk($sformatf("stream%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_out_valid});
            chk($sformatf("stream%0d_in_ready", i),  {31'd0, bus.in_ready},  {31'd0, tbl[i].e_in_ready});
            chk($sformatf("stream%0d_opa", i),       bus.out_opa, tbl[i].e_opa);
            chk($sformatf("stream%0d_opb", i),       bus.out_opb, tbl[i].e_opb);
            chk($sformatf("stream%0d_fast", i),      {31'd0, bus.out_fast},     {31'd0, tbl[i].e_fast});
            chk($sformatf("stream%0d_sxor", i),      {31'd0, bus.out_sign_xor}, {31'd0, tbl[i].e_sxor});
            chk($sformatf("stream%0d_special", i),   {31'd0, bus.out_special},  {31'd0, tbl[i].e_special});
            chk($sformatf("stream%0d_cnt", i),       {24'd0, bus.special_cnt},  {24'd0, tbl[i].e_cnt});
            step();
        end

        // Asynchronous reset with two entries held; special_cnt is 2 beforehand
        drive(1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, 32'h0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, bus.out_valid},   32'd0);
        chk("async_rst_in_ready",  {31'd0, bus.in_ready},    32'd0);
        chk("async_rst_cnt",       {24'd0, bus.special_cnt}, 32'd0);
        chk("async_rst_opa",       bus.out_opa,              32'd0);
        #1 rst = 1'b0;
        #1;
        chk("rel_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("no_stale_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure
        do_reset();
        drive(1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        chk("bp_rdy0", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(1'b1, 32'h2, 32'h0, 1'b0, 1'b0);
        chk("bp_rdy1", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_head1", bus.out_opa, 32'h1);
        step();
        drive(1'b1, 32'h3, 32'h0, 1'b0, 1'b0);
        chk("bp_rdy2", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head2", bus.out_opa, 32'h1);
        step();
        chk("bp_rdy3", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_stable", bus.out_opa, 32'h1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_rdy_after_pop", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_head_2", bus.out_opa, 32'h2);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bp_rdy_full_again", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_order2", bus.out_opa, 32'h2);
        step();
        chk("bp_order3", bus.out_opa, 32'h3);
        step();
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Simultaneous push and pop at count 1 for 10 cycles
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10, 32'h100 + k, 32'h0, 1'b0, 1'b1);
            if (k == 0) begin
                chk("pp_first_empty", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                chk($sformatf("pp%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("pp%0d_ready", k), {31'd0, bus.in_ready},  32'd1);
                chk($sformatf("pp%0d_opa", k),   bus.out_opa, 32'h100 + k - 1);
            end
            step();
        end
        chk("pp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Counter saturation with special operands streamed continuously
        do_reset();
        drive(1'b1, 32'hFF800000, 32'h0, 1'b0, 1'b1);
        repeat (255) step();
        chk("sat_254", {24'd0, bus.special_cnt}, 32'd254);
        step();
        chk("sat_255", {24'd0, bus.special_cnt}, 32'd255);
        repeat (5) step();
        bus.in_valid = 1'b0;
        step();
        chk("sat_hold", {24'd0, bus.special_cnt}, 32'd255);

        // Fast tag ordering under random out_ready
        do_reset();
        fast_pat = 3'b101;
        fast_got = 3'b000;
        m = 0;
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            drive(sent < 3, 32'hA0 + sent, 32'h0, fast_pat[sent % 3], 1'($urandom_range(0, 1)));
            #1;
            chk("ft_in_ready",  {31'd0, bus.in_ready},  {31'd0, m != 2});
            chk("ft_out_valid", {31'd0, bus.out_valid}, {31'd0, m != 0});
            push = bus.in_valid && (m != 2);
            pop  = (m != 0) && bus.out_ready;
            if (m != 0) begin
                chk("ft_head_opa",  bus.out_opa, q_opa[0]);
                chk("ft_head_fast", {31'd0, bus.out_fast}, {31'd0, q_fast[0]});
            end
            if (pop) begin
                fast_got[got] = q_fast[0];
                void'(q_opa.pop_front());
                void'(q_fast.pop_front());
                got++;
                m--;
            end
            if (push) begin
                q_opa.push_back(32'hA0 + sent);
                q_fast.push_back(fast_pat[sent]);
                sent++;
                m++;
            end
            step();
        end
        chk("ft_all_out", got, 32'd3);
        chk("ft_sequence", {29'd0, fast_got}, {29'd0, fast_pat});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
